// File: rtl/pc_redirect_unit.sv
// Fetch PC register with branch/jump redirect control. Redirects that arrive
// while instruction memory is stalled are held pending until fetch can take them.
module pc_redirect_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned COUNT_W  = 16
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               PC_SEL_IN,
  input  logic               EX_VALID,
  input  logic [31:0]        BRANCH_TARGET,
  input  logic               HOLD,
  input  logic               IMEM_BUSYWAIT,
  output logic [31:0]        PC_OUT,
  output logic [31:0]        PC_PLUS_4,
  output logic               FLUSH,
  output logic               PENDING,
  output logic               MISALIGN_ERR,
  output logic [COUNT_W-1:0] REDIRECT_COUNT
);

  typedef enum logic {
    ST_RUN,
    ST_WAIT
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        redirect;
  logic        accept;
  logic [31:0] target_aligned;
  logic [31:0] pending_target;
  logic [31:0] pc_next;

  assign redirect       = PC_SEL_IN & EX_VALID;
  assign target_aligned = {BRANCH_TARGET[31:2], 2'b00};
  assign accept         = (state == ST_RUN) && redirect;
  assign PC_PLUS_4      = PC_OUT + 32'd4;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= ST_RUN;
    end else begin
      state <= state_next;
    end
  end

  // In WAIT the EX stage is frozen and re-presents the same branch, so it is ignored.
  always_comb begin
    state_next = state;
    case (state)
      ST_RUN:  if (redirect && IMEM_BUSYWAIT) state_next = ST_WAIT;
      ST_WAIT: if (!IMEM_BUSYWAIT) state_next = ST_RUN;
      default: state_next = ST_RUN;
    endcase
  end

  always_comb begin
    FLUSH   = 1'b0;
    PENDING = (state == ST_WAIT);
    pc_next = PC_OUT;
    case (state)
      ST_RUN: begin
        if (redirect) begin
          if (!IMEM_BUSYWAIT) begin
            FLUSH   = 1'b1;
            pc_next = target_aligned;
          end
        end else if (!IMEM_BUSYWAIT && !HOLD) begin
          pc_next = PC_PLUS_4;
        end
      end
      ST_WAIT: begin
        if (!IMEM_BUSYWAIT) begin
          FLUSH   = 1'b1;
          pc_next = pending_target;
        end
      end
      default: ;
    endcase
    if (RESET) FLUSH = 1'b0;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      PC_OUT         <= RESET_PC;
      pending_target <= '0;
      MISALIGN_ERR   <= 1'b0;
      REDIRECT_COUNT <= '0;
    end else begin
      PC_OUT       <= pc_next;
      MISALIGN_ERR <= accept && (BRANCH_TARGET[1:0] != 2'b00);
      if (accept && IMEM_BUSYWAIT) begin
        pending_target <= target_aligned;
      end
      if (accept && (REDIRECT_COUNT != '1)) begin
        REDIRECT_COUNT <= REDIRECT_COUNT + COUNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Randomized plus directed bench for pc_redirect_unit; a reference model
// pushes per-cycle expectations into a queue drained by an independent monitor.
module tb_pc_redirect_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        ev = 1'b0;
  logic [31:0] tgt = '0;
  logic        hold = 1'b0;
  logic        busy = 1'b0;

  logic [31:0] pc, pc4, pc_b, pc4_b;
  logic        flush, pend, mis, flush_b, pend_b, mis_b;
  logic [15:0] cnt;
  logic [1:0]  cnt_b;

  always #5 clk = ~clk;

  pc_redirect_unit #(.RESET_PC(32'h0000_0000), .COUNT_W(16)) dut (
    .CLK(clk), .RESET(rst), .PC_SEL_IN(sel), .EX_VALID(ev), .BRANCH_TARGET(tgt),
    .HOLD(hold), .IMEM_BUSYWAIT(busy), .PC_OUT(pc), .PC_PLUS_4(pc4), .FLUSH(flush),
    .PENDING(pend), .MISALIGN_ERR(mis), .REDIRECT_COUNT(cnt)
  );

  pc_redirect_unit #(.RESET_PC(32'h0000_0000), .COUNT_W(2)) dut_small (
    .CLK(clk), .RESET(rst), .PC_SEL_IN(sel), .EX_VALID(ev), .BRANCH_TARGET(tgt),
    .HOLD(hold), .IMEM_BUSYWAIT(busy), .PC_OUT(pc_b), .PC_PLUS_4(pc4_b), .FLUSH(flush_b),
    .PENDING(pend_b), .MISALIGN_ERR(mis_b), .REDIRECT_COUNT(cnt_b)
  );

  typedef struct {
    logic [31:0] pc;
    logic        flush;
    logic        pend;
    logic        mis;
    int unsigned cnt;
  } exp_t;

  exp_t exp_q[$];
  int unsigned checks = 0;
  int unsigned passed = 0;

  // Reference model: architectural view of the fetch PC.
  logic [31:0] m_pc;
  bit          m_waiting;
  logic [31:0] m_target;
  bit          m_mis;
  int unsigned m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act === want) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
  endtask

  task automatic step(input bit s, input bit e, input logic [31:0] t,
                      input bit h, input bit b, input bit r);
    exp_t x;
    bit   redir;
    @(posedge clk);
    #1;
    sel = s; ev = e; tgt = t; hold = h; busy = b; rst = r;
    if (r) begin
      m_pc = 32'h0; m_waiting = 0; m_target = 32'h0; m_mis = 0; m_cnt = 0;
      x = '{pc: 32'h0, flush: 1'b0, pend: 1'b0, mis: 1'b0, cnt: 0};
      exp_q.push_back(x);
      return;
    end
    redir = s && e;
    x.pc    = m_pc;
    x.pend  = m_waiting;
    x.mis   = m_mis;
    x.cnt   = m_cnt;
    x.flush = m_waiting ? !b : (redir && !b);
    exp_q.push_back(x);
    if (m_waiting) begin
      m_mis = 0;
      if (!b) begin
        m_pc = m_target;
        m_waiting = 0;
      end
    end else if (redir) begin
      m_cnt++;
      m_mis = (t % 4) != 0;
      if (b) begin
        m_waiting = 1;
        m_target = t - (t % 4);
      end else begin
        m_pc = t - (t % 4);
      end
    end else begin
      m_mis = 0;
      if (!b && !h) m_pc = m_pc + 32'd4;
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc_out", pc, e.pc);
        chk("pc_plus_4", pc4, e.pc + 32'd4);
        chk("flush", 32'(flush), 32'(e.flush));
        chk("pending", 32'(pend), 32'(e.pend));
        chk("misalign_err", 32'(mis), 32'(e.mis));
        chk("redirect_count", 32'(cnt), (e.cnt > 65535) ? 32'd65535 : 32'(e.cnt));
        chk("redirect_count_w2", 32'(cnt_b), (e.cnt > 3) ? 32'd3 : 32'(e.cnt));
      end
    end
  end

  initial begin : driver
    logic [31:0] rt;
    // reset, then four free-running cycles
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    repeat (4) step(0, 0, 0, 0, 0, 0);
    // direct redirect at PC 0x10, then a bubble with sel high
    step(1, 1, 32'h100, 0, 0, 0);
    step(1, 0, 32'h300, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    // redirect under a three-cycle IMEM stall
    step(1, 1, 32'h200, 0, 1, 0);
    step(1, 1, 32'h200, 0, 1, 0);
    step(1, 1, 32'h200, 0, 1, 0);
    step(1, 1, 32'h200, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    // HOLD alone freezes; redirect beats HOLD
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(1, 1, 32'h40, 1, 0, 0);
    // misaligned target
    step(1, 1, 32'h1003, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    // wrap-around at the top of the address space
    step(1, 1, 32'hFFFF_FFFC, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    // reset pulsed while a redirect is pending
    step(1, 1, 32'h800, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      rt = $urandom;
      if ($urandom_range(0, 15) == 0) rt = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
      step($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0, rt,
           $urandom_range(0, 4) == 0, $urandom_range(0, 9) < 3,
           $urandom_range(0, 49) == 0);
    end
    repeat (3) @(posedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
